// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU (AC/E/PC/IR/AR/IEN) with a req/ack memory port that
// tolerates wait states, an interrupt cycle and a halt state.
module acc_cpu_core #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DWIDTH-1:0]     o_mem_wdata,
  input  logic [DWIDTH-1:0]     i_mem_rdata,
  input  logic                  i_mem_ack,
  input  logic                  i_irq,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [DWIDTH-1:0]     o_ac,
  output logic                  o_halted
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StIndirect, StExec, StIszWr, StRegio, StIntr, StHalt
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] AOne = ADDR_WIDTH'(1);
  localparam logic [DWIDTH-1:0]     DOne = DWIDTH'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, ar_q, ar_d, addr_q, addr_d;
  logic [DWIDTH-1:0]       ac_q, ac_d, ir_q, ir_d, wdata_q, wdata_d;
  logic                    e_q, e_d, ien_q, ien_d, req_q, req_d, we_q, we_d;
  logic                    halted_q, halted_d;

  logic [2:0]              opcode;
  logic                    ind;
  logic [DWIDTH:0]         sum;
  logic [DWIDTH:0]         rot;
  logic [DWIDTH-1:0]       r_ac;
  logic                    r_e;
  logic                    skip;

  assign opcode = ir_q[DWIDTH-2 -: 3];
  assign ind    = ir_q[DWIDTH-1];
  assign sum    = {1'b0, ac_q} + {1'b0, i_mem_rdata};

  // Register-reference micro-ops, applied in priority order; skips use pre-instruction AC/E.
  always_comb begin
    r_ac = ac_q;
    r_e  = e_q;
    rot  = '0;
    if (ir_q[11]) r_ac = '0;
    if (ir_q[10]) r_e = 1'b0;
    if (ir_q[9])  r_ac = ~r_ac;
    if (ir_q[8])  r_e = ~r_e;
    rot = {r_ac, r_e};
    if (ir_q[7]) begin
      {r_ac, r_e} = {rot[0], rot[DWIDTH:1]};
    end else if (ir_q[6]) begin
      {r_ac, r_e} = {rot[DWIDTH-1:0], rot[DWIDTH]};
    end
    if (ir_q[5]) r_ac = r_ac + DOne;
    skip = (ir_q[4] & ~ac_q[DWIDTH-1]) | (ir_q[3] & ac_q[DWIDTH-1]) |
           (ir_q[2] & (ac_q == '0)) | (ir_q[1] & ~e_q);
  end

  // Each memory state spends its first cycle (req low) issuing the access, then waits for ack.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ar_d     = ar_q;
    ac_d     = ac_q;
    ir_d     = ir_q;
    e_d      = e_q;
    ien_d    = ien_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    halted_d = halted_q;
    unique case (state_q)
      StFetch: begin
        if (!req_q) begin
          req_d = 1'b1;
          if (ien_q && i_irq) begin
            we_d    = 1'b1;
            addr_d  = '0;
            wdata_d = DWIDTH'(pc_q);
            state_d = StIntr;
          end else begin
            we_d   = 1'b0;
            addr_d = pc_q;
          end
        end else if (i_mem_ack) begin
          req_d   = 1'b0;
          ir_d    = i_mem_rdata;
          pc_d    = pc_q + AOne;
          state_d = StDecode;
        end
      end
      StDecode: begin
        ar_d = ir_q[ADDR_WIDTH-1:0];
        if (opcode == 3'd7)  state_d = StRegio;
        else if (ind)        state_d = StIndirect;
        else                 state_d = StExec;
      end
      StIndirect: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = ar_q;
        end else if (i_mem_ack) begin
          req_d   = 1'b0;
          ar_d    = i_mem_rdata[ADDR_WIDTH-1:0];
          state_d = StExec;
        end
      end
      StExec: begin
        if (opcode == 3'd4) begin
          pc_d    = ar_q;
          state_d = StFetch;
        end else if (!req_q) begin
          req_d   = 1'b1;
          we_d    = (opcode == 3'd3) || (opcode == 3'd5);
          addr_d  = ar_q;
          wdata_d = (opcode == 3'd5) ? DWIDTH'(pc_q) : ac_q;
        end else if (i_mem_ack) begin
          req_d   = 1'b0;
          state_d = StFetch;
          case (opcode)
            3'd0: ac_d = ac_q & i_mem_rdata;
            3'd1: {e_d, ac_d} = sum;
            3'd2: ac_d = i_mem_rdata;
            3'd5: pc_d = ar_q + AOne;
            3'd6: begin
              // Chain the write-back directly onto the read so req stays high.
              req_d   = 1'b1;
              we_d    = 1'b1;
              wdata_d = i_mem_rdata + DOne;
              state_d = StIszWr;
            end
            default: ;
          endcase
        end
      end
      StIszWr: begin
        if (i_mem_ack) begin
          req_d   = 1'b0;
          state_d = StFetch;
          if (wdata_q == '0) pc_d = pc_q + AOne;
        end
      end
      StRegio: begin
        state_d = StFetch;
        if (ind) begin
          if (ir_q[7]) ien_d = 1'b1;
          if (ir_q[6]) ien_d = 1'b0;
        end else begin
          ac_d = r_ac;
          e_d  = r_e;
          if (skip) pc_d = pc_q + AOne;
          if (ir_q[0]) begin
            state_d  = StHalt;
            halted_d = 1'b1;
          end
        end
      end
      StIntr: begin
        if (i_mem_ack) begin
          req_d   = 1'b0;
          pc_d    = AOne;
          ien_d   = 1'b0;
          state_d = StFetch;
        end
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      pc_q     <= '0;
      ar_q     <= '0;
      ac_q     <= '0;
      ir_q     <= '0;
      e_q      <= 1'b0;
      ien_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ar_q     <= ar_d;
      ac_q     <= ac_d;
      ir_q     <= ir_d;
      e_q      <= e_d;
      ien_q    <= ien_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      halted_q <= halted_d;
    end
  end

  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_pc        = pc_q;
  assign o_ac        = ac_q;
  assign o_halted    = halted_q;

endmodule
